cdc_rx_packetizer: RTL and testbench

//  Packetizes the unflow-controlled UART RX byte stream into USB CDC bulk-IN packets.
//  - Sits between APB_Stream_UART rx_tvalid/rx_tdata and AHB_USBDevice cdc_in_*.
//  - Buffers bytes in a ring RAM and closes a packet on max size, line-idle timeout or forced flush.
//  - Presents each packet with its length up front, as the winusb_in tlen interface does.

---
 rtl/hflink_usb_pkg.sv | 35 +++
 rtl/cdc_len_fifo.sv | 67 ++++++
 rtl/cdc_rx_packetizer.sv | 288 ++++++++++++++++++++++++++++
 tb/tb_cdc_rx_packetizer.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hflink_usb_pkg.sv
// ---------------------------------------------------------------------------
// hflink_usb_pkg
// Shared constants and types for the USB CDC side of the HF link.
//   USB_MAX_PKT_HS / USB_MAX_PKT_FS : bulk max packet size (high / full speed)
//   TLEN_W                          : width of a packet length field
//   rd_state_e                      : packetizer read-side FSM states
//   sat_inc16                       : saturating 16-bit increment for counters
// ---------------------------------------------------------------------------
package hflink_usb_pkg;

  localparam int USB_MAX_PKT_HS = 512;
  localparam int USB_MAX_PKT_FS = 64;
  localparam int TLEN_W         = 12;

  localparam logic [TLEN_W-1:0] TLEN_ONE = 12'd1;
  localparam logic [TLEN_W-1:0] TLEN_TWO = 12'd2;

  typedef enum logic [1:0] {
    RD_IDLE = 2'd0,
    RD_LOAD = 2'd1,
    RD_XFER = 2'd2
  } rd_state_e;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    logic [15:0] result;
    if (value == 16'hFFFF) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/cdc_len_fifo.sv
// ---------------------------------------------------------------------------
// cdc_len_fifo
// Small synchronous FIFO holding the lengths of closed packets.
// Show-ahead: dout always reflects the oldest entry while !empty.
//   clk, rst_n : clock, async active-low reset
//   push, din  : write an entry (ignored when full)
//   pop        : drop the oldest entry (ignored when empty)
//   dout       : oldest entry
//   full/empty : occupancy flags
// ---------------------------------------------------------------------------
module cdc_len_fifo
  import hflink_usb_pkg::*;
#(
  parameter int WIDTH      = TLEN_W,
  parameter int DEPTH_LOG2 = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]    mem_r [DEPTH];
  logic [DEPTH_LOG2:0] wr_ptr_r;
  logic [DEPTH_LOG2:0] rd_ptr_r;
  logic                push_ok_s;
  logic                pop_ok_s;

  // Flags, gated strobes and show-ahead read; extra MSB separates full from empty.
  always_comb begin
    empty     = (wr_ptr_r == rd_ptr_r);
    full      = (wr_ptr_r[DEPTH_LOG2] != rd_ptr_r[DEPTH_LOG2]) &&
                (wr_ptr_r[DEPTH_LOG2-1:0] == rd_ptr_r[DEPTH_LOG2-1:0]);
    push_ok_s = push && !full;
    pop_ok_s  = pop && !empty;
    dout      = mem_r[rd_ptr_r[DEPTH_LOG2-1:0]];
  end

  // Entry storage (no reset needed; entries are only read once written).
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= din;
    end
  end

  // Read / write pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
      rd_ptr_r <= {(DEPTH_LOG2+1){1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + {{DEPTH_LOG2{1'b0}}, 1'b1};
      end
    end
  end

endmodule

// File: rtl/cdc_rx_packetizer.sv
// ---------------------------------------------------------------------------
// cdc_rx_packetizer
// Turns the UART RX byte stream (no backpressure) into length-prefixed USB
// CDC bulk-IN packets. Bytes land in a ring RAM; a packet closes on MAX_PKT
// bytes, on line idle for IDLE_CYCLES, or on flush. Closed lengths queue up
// and a read FSM streams each packet with its length presented up front.
//   hclk, hresetn          : clock, async active-low reset
//   in_tvalid, in_tdata    : RX byte strobe and data
//   flush                  : close the open packet now if non-empty
//   out_tvalid/tready/tdata/tlast/tlen : packet stream toward USB
//   level                  : bytes held (closed + open + in flight)
//   drop_cnt               : bytes lost to overflow, saturating
// ---------------------------------------------------------------------------
module cdc_rx_packetizer
  import hflink_usb_pkg::*;
#(
  parameter int DEPTH_LOG2  = 11,
  parameter int MAX_PKT     = USB_MAX_PKT_HS,
  parameter int IDLE_CYCLES = 2000,
  parameter int LENQ_LOG2   = 3
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                in_tvalid,
  input  logic [7:0]          in_tdata,
  input  logic                flush,
  output logic                out_tvalid,
  input  logic                out_tready,
  output logic [7:0]          out_tdata,
  output logic                out_tlast,
  output logic [TLEN_W-1:0]   out_tlen,
  output logic [DEPTH_LOG2:0] level,
  output logic [15:0]         drop_cnt
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2 + 1;
  localparam int TMR_W = (IDLE_CYCLES > 2) ? $clog2(IDLE_CYCLES) : 1;

  // Write side state
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  level_r;
  logic [TLEN_W-1:0] open_cnt_r;
  logic [TMR_W-1:0]  idle_tmr_r;
  logic              close_pend_r;
  logic [15:0]       drop_cnt_r;

  // Write side decode
  logic [PTR_W-1:0]  level_s;
  logic [PTR_W-1:0]  wr_ptr_nxt_s;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [TLEN_W-1:0] open_cnt_nxt_s;
  logic              close_pend_nxt_s;
  logic              ram_full_s;
  logic              open_max_s;
  logic              open_nz_s;
  logic              wr_en_s;
  logic              max_hit_s;
  logic              tmo_s;
  logic              soft_close_s;
  logic              close_req_s;
  logic              do_close_s;
  logic              drop_s;
  logic [TLEN_W-1:0] q_din_s;

  // Length queue
  logic [TLEN_W-1:0] q_dout_s;
  logic              q_full_s;
  logic              q_empty_s;
  logic              q_pop_s;

  // Ring RAM and read side
  logic [7:0]            mem_r [DEPTH];
  logic [7:0]            ram_q_r;
  logic                  ram_re_s;
  logic [1:0]            rd_off_s;
  logic [DEPTH_LOG2-1:0] rd_addr_s;
  rd_state_e             state_r;
  rd_state_e             state_nxt_s;
  logic [TLEN_W-1:0]     idx_r;
  logic                  rd_adv_s;

  // Write acceptance, packet close arbitration and next-state of the write side.
  always_comb begin
    level_s    = wr_ptr_r - rd_ptr_r;
    ram_full_s = (level_s == PTR_W'(DEPTH));
    open_max_s = (open_cnt_r == TLEN_W'(MAX_PKT));
    open_nz_s  = (open_cnt_r != {TLEN_W{1'b0}});
    // A packet already at MAX_PKT whose close is stuck behind a full queue
    // cannot take more bytes.
    wr_en_s    = in_tvalid && !ram_full_s && !(open_max_s && q_full_s);
    drop_s     = in_tvalid && !wr_en_s;
    // The MAX_PKT-th byte closes its own packet in the cycle it is written.
    max_hit_s  = wr_en_s && (open_cnt_r == TLEN_W'(MAX_PKT - 1));
    tmo_s      = open_nz_s && !in_tvalid && (idle_tmr_r == {TMR_W{1'b0}});
    // Idle/flush closes (including one deferred earlier) exclude the byte
    // arriving in the same cycle.
    soft_close_s = open_nz_s && (tmo_s || flush || close_pend_r);
    close_req_s  = max_hit_s || open_max_s || soft_close_s;
    do_close_s   = close_req_s && !q_full_s;

    if (max_hit_s) begin
      q_din_s = open_cnt_r + TLEN_ONE;
    end else begin
      q_din_s = open_cnt_r;
    end

    if (do_close_s && max_hit_s) begin
      open_cnt_nxt_s = {TLEN_W{1'b0}};
    end else if (do_close_s) begin
      open_cnt_nxt_s = {{(TLEN_W-1){1'b0}}, wr_en_s};
    end else begin
      open_cnt_nxt_s = open_cnt_r + {{(TLEN_W-1){1'b0}}, wr_en_s};
    end

    if (do_close_s) begin
      close_pend_nxt_s = 1'b0;
    end else if (soft_close_s) begin
      close_pend_nxt_s = 1'b1;
    end else begin
      close_pend_nxt_s = close_pend_r;
    end

    wr_ptr_nxt_s = wr_ptr_r + {{(PTR_W-1){1'b0}}, wr_en_s};
    rd_ptr_nxt_s = rd_ptr_r + {{(PTR_W-1){1'b0}}, rd_adv_s};
  end

  // Write pointer, open packet count, pending close, drop counter and level.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      level_r      <= {PTR_W{1'b0}};
      open_cnt_r   <= {TLEN_W{1'b0}};
      close_pend_r <= 1'b0;
      drop_cnt_r   <= 16'd0;
    end else begin
      wr_ptr_r     <= wr_ptr_nxt_s;
      rd_ptr_r     <= rd_ptr_nxt_s;
      level_r      <= wr_ptr_nxt_s - rd_ptr_nxt_s;
      open_cnt_r   <= open_cnt_nxt_s;
      close_pend_r <= close_pend_nxt_s;
      if (drop_s) begin
        drop_cnt_r <= sat_inc16(drop_cnt_r);
      end
    end
  end

  // Line-idle timer: reloads on every input byte, runs down while a packet is open.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      idle_tmr_r <= TMR_W'(IDLE_CYCLES - 1);
    end else if (in_tvalid || !open_nz_s) begin
      idle_tmr_r <= TMR_W'(IDLE_CYCLES - 1);
    end else if (idle_tmr_r != {TMR_W{1'b0}}) begin
      idle_tmr_r <= idle_tmr_r - {{(TMR_W-1){1'b0}}, 1'b1};
    end
  end

  // Ring RAM write port.
  always_ff @(posedge hclk) begin
    if (wr_en_s) begin
      mem_r[wr_ptr_r[DEPTH_LOG2-1:0]] <= in_tdata;
    end
  end

  // Ring RAM registered read port.
  always_ff @(posedge hclk) begin
    if (ram_re_s) begin
      ram_q_r <= mem_r[rd_addr_s];
    end
  end

  cdc_len_fifo #(
    .WIDTH      (TLEN_W),
    .DEPTH_LOG2 (LENQ_LOG2)
  ) u_len_fifo (
    .clk   (hclk),
    .rst_n (hresetn),
    .push  (do_close_s),
    .din   (q_din_s),
    .pop   (q_pop_s),
    .dout  (q_dout_s),
    .full  (q_full_s),
    .empty (q_empty_s)
  );

  // Read FSM state register.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_r <= RD_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Read FSM next state and RAM fetch control. rd_ptr points at the byte on
  // out_tdata; ram_q_r is kept one byte ahead so a handshake never bubbles.
  always_comb begin
    state_nxt_s = state_r;
    q_pop_s     = 1'b0;
    ram_re_s    = 1'b0;
    rd_off_s    = 2'd0;
    rd_adv_s    = 1'b0;
    case (state_r)
      RD_IDLE: begin
        if (!q_empty_s) begin
          q_pop_s     = 1'b1;
          ram_re_s    = 1'b1;
          rd_off_s    = 2'd0;
          state_nxt_s = RD_LOAD;
        end else begin
          state_nxt_s = RD_IDLE;
        end
      end
      RD_LOAD: begin
        ram_re_s    = 1'b1;
        rd_off_s    = 2'd1;
        state_nxt_s = RD_XFER;
      end
      RD_XFER: begin
        if (out_tready) begin
          rd_adv_s = 1'b1;
          if (out_tlast) begin
            state_nxt_s = RD_IDLE;
          end else begin
            ram_re_s    = 1'b1;
            rd_off_s    = 2'd2;
            state_nxt_s = RD_XFER;
          end
        end else begin
          state_nxt_s = RD_XFER;
        end
      end
      default: begin
        state_nxt_s = RD_IDLE;
      end
    endcase
    rd_addr_s = rd_ptr_r[DEPTH_LOG2-1:0] + {{(DEPTH_LOG2-2){1'b0}}, rd_off_s};
  end

  // Registered stream outputs; held while out_tvalid && !out_tready.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      out_tvalid <= 1'b0;
      out_tlast  <= 1'b0;
      out_tdata  <= 8'd0;
      out_tlen   <= {TLEN_W{1'b0}};
      idx_r      <= {TLEN_W{1'b0}};
    end else begin
      case (state_r)
        RD_IDLE: begin
          if (q_pop_s) begin
            out_tlen <= q_dout_s;
          end
        end
        RD_LOAD: begin
          out_tdata  <= ram_q_r;
          out_tvalid <= 1'b1;
          out_tlast  <= (out_tlen == TLEN_ONE);
          idx_r      <= {TLEN_W{1'b0}};
        end
        RD_XFER: begin
          if (out_tready) begin
            if (out_tlast) begin
              out_tvalid <= 1'b0;
              out_tlast  <= 1'b0;
            end else begin
              out_tdata <= ram_q_r;
              idx_r     <= idx_r + TLEN_ONE;
              // Next index is idx_r+1; it is last when idx_r+1 == out_tlen-1.
              out_tlast <= ((idx_r + TLEN_TWO) == out_tlen);
            end
          end
        end
        default: begin
          out_tvalid <= 1'b0;
          out_tlast  <= 1'b0;
        end
      endcase
    end
  end

  assign level    = level_r;
  assign drop_cnt = drop_cnt_r;

endmodule

// File: tb/tb_cdc_rx_packetizer.sv
module tb_cdc_rx_packetizer;

  localparam int IDLE = 2000;

  logic        hclk = 1'b0;
  logic        hresetn = 1'b0;
  logic        in_tvalid = 1'b0;
  logic [7:0]  in_tdata = 8'd0;
  logic        flush = 1'b0;
  logic        out_tvalid;
  logic        out_tready;
  logic [7:0]  out_tdata;
  logic        out_tlast;
  logic [11:0] out_tlen;
  logic [11:0] level;
  logic [15:0] drop_cnt;

  int pass_cnt = 0;
  int check_cnt = 0;
  logic rand_ready = 1'b0;
  logic ready_cfg = 1'b0;
  logic [20:0] rx_q[$];
  logic [20:0] exp_q[$];

  cdc_rx_packetizer #(
    .DEPTH_LOG2  (11),
    .MAX_PKT     (512),
    .IDLE_CYCLES (IDLE),
    .LENQ_LOG2   (3)
  ) dut (
    .hclk       (hclk),
    .hresetn    (hresetn),
    .in_tvalid  (in_tvalid),
    .in_tdata   (in_tdata),
    .flush      (flush),
    .out_tvalid (out_tvalid),
    .out_tready (out_tready),
    .out_tdata  (out_tdata),
    .out_tlast  (out_tlast),
    .out_tlen   (out_tlen),
    .level      (level),
    .drop_cnt   (drop_cnt)
  );

  always #5 hclk = ~hclk;

  // Sole driver of out_tready: fixed level or 50% random.
  initial begin
    out_tready = 1'b0;
    forever begin
      @(posedge hclk);
      #2;
      out_tready = rand_ready ? (($urandom & 32'd1) != 32'd0) : ready_cfg;
    end
  end

  // Capture every accepted byte as {tlen, tlast, tdata}.
  always @(negedge hclk) begin
    if (hresetn && out_tvalid && out_tready) rx_q.push_back({out_tlen, out_tlast, out_tdata});
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [20:0] mk(input int len, input logic last, input int d);
    logic [11:0] l;
    logic [7:0]  b;
    l = len[11:0];
    b = d[7:0];
    return {l, last, b};
  endfunction

  task automatic tick();
    @(posedge hclk);
    #1;
  endtask

  task automatic put(input logic [7:0] b);
    in_tvalid = 1'b1;
    in_tdata  = b;
    tick();
    in_tvalid = 1'b0;
  endtask

  task automatic wait_rx(input int n, input int budget);
    int k;
    k = 0;
    while (rx_q.size() < n && k < budget) begin
      tick();
      k++;
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    check_cnt++; if (out_tvalid !== 1'b0) $display("FAIL rst_tvalid: got %b want 0", out_tvalid); else pass_cnt++;
    check_cnt++; if (out_tlast !== 1'b0) $display("FAIL rst_tlast: got %b want 0", out_tlast); else pass_cnt++;
    check_cnt++; if (out_tlen !== 12'd0) $display("FAIL rst_tlen: got %0d want 0", out_tlen); else pass_cnt++;
    check_cnt++; if (out_tdata !== 8'd0) $display("FAIL rst_tdata: got %h want 00", out_tdata); else pass_cnt++;
    check_cnt++; if (level !== 12'd0) $display("FAIL rst_level: got %0d want 0", level); else pass_cnt++;
    check_cnt++; if (drop_cnt !== 16'd0) $display("FAIL rst_drop: got %0d want 0", drop_cnt); else pass_cnt++;
    @(negedge hclk);
    hresetn = 1'b1;
    tick();
  endtask

  task automatic test_idle_close();
    int bad, first;
    ready_cfg = 1'b1;
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      put(8'h41 + i[7:0]);
      exp_q.push_back(mk(5, i == 4, 8'h41 + i));
    end
    check_cnt++; if (level !== 12'd5) $display("FAIL idle_level: got %0d want 5", level); else pass_cnt++;
    // Last write in cycle t; close at t+IDLE; valid from t+IDLE+3.
    repeat (IDLE + 1) tick();
    check_cnt++; if (out_tvalid !== 1'b0) $display("FAIL idle_early_valid: got %b want 0", out_tvalid); else pass_cnt++;
    tick();
    check_cnt++; if (out_tvalid !== 1'b1) $display("FAIL idle_latency_valid: got %b want 1", out_tvalid); else pass_cnt++;
    check_cnt++; if (out_tlen !== 12'd5) $display("FAIL idle_tlen: got %0d want 5", out_tlen); else pass_cnt++;
    check_cnt++; if (out_tdata !== 8'h41) $display("FAIL idle_first_byte: got %h want 41", out_tdata); else pass_cnt++;
    wait_rx(5, 50);
    bad = 0; first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    check_cnt++;
    if (bad != 0 || rx_q.size() != exp_q.size())
      $display("FAIL idle_stream: %0d wrong (first idx %0d), got %0d bytes, want %0d", bad, first, rx_q.size(), exp_q.size());
    else pass_cnt++;
    repeat (2) tick();
    check_cnt++; if (level !== 12'd0) $display("FAIL idle_level_end: got %0d want 0", level); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int bad, first;
    ready_cfg = 1'b1;
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 1200; i++) begin
      put(i[7:0]);
      exp_q.push_back(mk((i < 1024) ? 512 : 176, (i == 511) || (i == 1023) || (i == 1199), i));
    end
    wait_rx(1200, IDLE + 2000);
    bad = 0; first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    check_cnt++;
    if (bad != 0 || rx_q.size() != exp_q.size())
      $display("FAIL b2b_stream: %0d wrong (first idx %0d), got %0d bytes, want %0d", bad, first, rx_q.size(), exp_q.size());
    else pass_cnt++;
    repeat (2) tick();
    check_cnt++; if (level !== 12'd0) $display("FAIL b2b_level_end: got %0d want 0", level); else pass_cnt++;
    check_cnt++; if (drop_cnt !== 16'd0) $display("FAIL b2b_drop: got %0d want 0", drop_cnt); else pass_cnt++;
  endtask

  task automatic test_overflow();
    int bad, first;
    ready_cfg = 1'b0;
    tick();
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 2058; i++) begin
      put(i[7:0]);
      if (i < 2048) exp_q.push_back(mk(512, (i % 512) == 511, i));
    end
    repeat (4) tick();
    check_cnt++; if (level !== 12'd2048) $display("FAIL ovf_level: got %0d want 2048", level); else pass_cnt++;
    check_cnt++; if (drop_cnt !== 16'd10) $display("FAIL ovf_drop: got %0d want 10", drop_cnt); else pass_cnt++;
    check_cnt++; if (out_tvalid !== 1'b1) $display("FAIL ovf_stall_valid: got %b want 1", out_tvalid); else pass_cnt++;
    check_cnt++; if (out_tdata !== 8'h00) $display("FAIL ovf_stall_data: got %h want 00", out_tdata); else pass_cnt++;
    check_cnt++; if (out_tlen !== 12'd512) $display("FAIL ovf_stall_tlen: got %0d want 512", out_tlen); else pass_cnt++;
    ready_cfg = 1'b1;
    wait_rx(2048, 3000);
    bad = 0; first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    check_cnt++;
    if (bad != 0 || rx_q.size() != exp_q.size())
      $display("FAIL ovf_stream: %0d wrong (first idx %0d), got %0d bytes, want %0d", bad, first, rx_q.size(), exp_q.size());
    else pass_cnt++;
    repeat (2) tick();
    check_cnt++; if (level !== 12'd0) $display("FAIL ovf_level_end: got %0d want 0", level); else pass_cnt++;
  endtask

  task automatic test_flush();
    int bad, first;
    ready_cfg = 1'b1;
    rx_q.delete();
    exp_q.delete();
    put(8'hA0); put(8'hA1); put(8'hA2);
    in_tvalid = 1'b1; in_tdata = 8'hA3; flush = 1'b1;
    tick();
    in_tvalid = 1'b0; flush = 1'b0;
    exp_q.push_back(mk(3, 1'b0, 8'hA0));
    exp_q.push_back(mk(3, 1'b0, 8'hA1));
    exp_q.push_back(mk(3, 1'b1, 8'hA2));
    exp_q.push_back(mk(1, 1'b1, 8'hA3));
    wait_rx(3, 20);
    check_cnt++; if (rx_q.size() !== 3) $display("FAIL flush_first_pkt: got %0d bytes want 3", rx_q.size()); else pass_cnt++;
    wait_rx(4, IDLE + 50);
    bad = 0; first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    check_cnt++;
    if (bad != 0 || rx_q.size() != exp_q.size())
      $display("FAIL flush_stream: %0d wrong (first idx %0d), got %0d bytes, want %0d", bad, first, rx_q.size(), exp_q.size());
    else pass_cnt++;
    // Flush with nothing open must not create a packet.
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (6) tick();
    check_cnt++; if (out_tvalid !== 1'b0) $display("FAIL flush_empty_valid: got %b want 0", out_tvalid); else pass_cnt++;
    check_cnt++; if (rx_q.size() !== 4) $display("FAIL flush_empty_bytes: got %0d want 4", rx_q.size()); else pass_cnt++;
  endtask

  task automatic test_queue_full();
    int bad, first;
    int c;
    ready_cfg = 1'b0;
    tick();
    rx_q.delete();
    exp_q.delete();
    c = 8'h10;
    // Packets of 1..9 bytes: the first sits in the read FSM, the rest fill the queue.
    for (int p = 0; p < 9; p++) begin
      for (int k = 0; k <= p; k++) begin
        put(c[7:0]);
        exp_q.push_back(mk(p + 1, k == p, c));
        c++;
      end
      flush = 1'b1; tick(); flush = 1'b0;
    end
    // Tenth packet: flush finds the queue full, so later bytes join it.
    for (int k = 0; k < 5; k++) begin
      put(c[7:0]);
      exp_q.push_back(mk(5, k == 4, c));
      c++;
      if (k == 2) begin
        flush = 1'b1; tick(); flush = 1'b0;
      end
    end
    repeat (3) tick();
    check_cnt++; if (out_tlen !== 12'd1) $display("FAIL qf_head_tlen: got %0d want 1", out_tlen); else pass_cnt++;
    check_cnt++; if (level !== 12'd50) $display("FAIL qf_level: got %0d want 50", level); else pass_cnt++;
    rand_ready = 1'b1;
    wait_rx(50, 1500);
    rand_ready = 1'b0;
    bad = 0; first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    check_cnt++;
    if (bad != 0 || rx_q.size() != exp_q.size())
      $display("FAIL qf_stream: %0d wrong (first idx %0d), got %0d bytes, want %0d", bad, first, rx_q.size(), exp_q.size());
    else pass_cnt++;
    repeat (3) tick();
    check_cnt++; if (level !== 12'd0) $display("FAIL qf_level_end: got %0d want 0", level); else pass_cnt++;
    check_cnt++; if (drop_cnt !== 16'd10) $display("FAIL qf_drop: got %0d want 10", drop_cnt); else pass_cnt++;
  endtask

  task automatic test_reset_mid_xfer();
    int bad, first;
    ready_cfg = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) put(8'hE0 + i[7:0]);
    flush = 1'b1; tick(); flush = 1'b0;
    repeat (6) tick();
    check_cnt++; if (out_tvalid !== 1'b1) $display("FAIL mid_pre_valid: got %b want 1", out_tvalid); else pass_cnt++;
    #2;
    hresetn = 1'b0;
    #1;
    check_cnt++; if (out_tvalid !== 1'b0) $display("FAIL mid_rst_tvalid: got %b want 0", out_tvalid); else pass_cnt++;
    check_cnt++; if (out_tdata !== 8'd0) $display("FAIL mid_rst_tdata: got %h want 00", out_tdata); else pass_cnt++;
    check_cnt++; if (out_tlen !== 12'd0) $display("FAIL mid_rst_tlen: got %0d want 0", out_tlen); else pass_cnt++;
    check_cnt++; if (level !== 12'd0) $display("FAIL mid_rst_level: got %0d want 0", level); else pass_cnt++;
    check_cnt++; if (drop_cnt !== 16'd0) $display("FAIL mid_rst_drop: got %0d want 0", drop_cnt); else pass_cnt++;
    repeat (2) @(posedge hclk);
    @(negedge hclk);
    hresetn = 1'b1;
    ready_cfg = 1'b1;
    tick();
    rx_q.delete();
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      put(8'hC0 + i[7:0]);
      exp_q.push_back(mk(4, i == 3, 8'hC0 + i));
    end
    flush = 1'b1; tick(); flush = 1'b0;
    wait_rx(4, 50);
    bad = 0; first = -1;
    for (int i = 0; i < exp_q.size(); i++)
      if (i >= rx_q.size() || rx_q[i] !== exp_q[i]) begin bad++; if (first < 0) first = i; end
    check_cnt++;
    if (bad != 0 || rx_q.size() != exp_q.size())
      $display("FAIL mid_new_stream: %0d wrong (first idx %0d), got %0d bytes, want %0d", bad, first, rx_q.size(), exp_q.size());
    else pass_cnt++;
    repeat (2) tick();
    check_cnt++; if (level !== 12'd0) $display("FAIL mid_level_end: got %0d want 0", level); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_idle_close();
    test_back_to_back();
    test_overflow();
    test_flush();
    test_queue_full();
    test_reset_mid_xfer();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
